zedboard_btn_debounce: RTL and testbench
========================================

// Module: zedboard_btn_debounce
// PURPOSE
//  Input-side companion to the Zedboard LED blinker. Debounces the board push-buttons on the
//  125 MHz fabric clock: synchronises each raw pin, filters bounce, and emits a clean level,
//  one-cycle press/release pulses, an optional long-press pulse, and a wrapping press-event counter.
//  Sits between the top-level button pins and user logic (e.g. LED mode control).
// PARAMETERS
//  N_BTN        5              number of button channels (Zedboard BTNC/U/D/L/R)
//  CNT_W        27             width of debounce and hold counters
//  DEBOUNCE_CNT 27'd1249999    terminal count for stable input (10 ms at 125 MHz)
//  LONG_CNT     27'd124999999  terminal count for long press (1 s at 125 MHz)
// PORTS
//  clk          in   1      125 MHz fabric clock
//  rst          in   1      asynchronous reset, active-high
//  btn_in       in   N_BTN  raw button pins, asynchronous, 1 = pressed
//  btn_level    out  N_BTN  debounced level per channel
//  btn_press    out  N_BTN  1-cycle pulse on debounced press
//  btn_release  out  N_BTN  1-cycle pulse on debounced release
//  btn_long     out  N_BTN  1-cycle pulse when a press is held LONG_CNT+1 cycles
//  evt_count    out  8      total debounced presses, all channels, modulo 256
// BEHAVIOUR
//  - Reset (async assert, released on clk): sync flops 0, all FSMs IDLE, counters 0, every output 0.
//  - Per channel: 2-flop synchroniser; FSM input is sync2 (2-cycle synchroniser latency).
//  - FSM states and transitions:
//    IDLE:   sync2=1 -> DB_PRESS, dcnt<=0.
//    DB_PRESS: sync2=0 -> IDLE (bounce rejected, no pulse); dcnt==DEBOUNCE_CNT -> HELD,
//             btn_level<=1, btn_press pulse, hcnt<=0; else dcnt++.
//    HELD:   sync2=0 -> DB_RELEASE, dcnt<=0; else hcnt++ (saturating at LONG_CNT).
//    DB_RELEASE: sync2=1 -> HELD (bounce, no pulse, hcnt preserved); dcnt==DEBOUNCE_CNT -> IDLE,
//             btn_level<=0, btn_release pulse; else dcnt++.
//  - Latency: E0 = first clk edge sampling btn_in high, input stable afterwards. btn_press and
//    btn_level rise after edge E0+DEBOUNCE_CNT+3; btn_press is high for exactly one cycle.
//    Release is symmetric.
//  - Any glitch shorter than DEBOUNCE_CNT+1 cycles at sync2 produces no output change.
//  - btn_press and btn_release are never high together on one channel; consecutive presses are
//    separated by at least 2*(DEBOUNCE_CNT+1) cycles.
//  - evt_count += popcount(btn_press) each cycle; simultaneous presses on k channels add k in one
//    cycle; wraps 255 -> 0 without flag.
//  - Reset mid-operation aborts all state immediately. A button still held when reset is released
//    is treated as a new press: full debounce, then btn_press.
//  - Channels are fully independent; no priority between channels.
// CONFIGURATION
//  ZB_BTN_LONG_PRESS_EN defined:
//    - HELD hcnt per channel.
//    - When hcnt==LONG_CNT-1 increments to LONG_CNT, btn_long pulses one cycle (once per press,
//      no repeat).
//    - hcnt clears only on entry to HELD from DB_PRESS.
//  ZB_BTN_LONG_PRESS_EN undefined:
//    - No hcnt registers; btn_long tied to 0.
//    - LONG_CNT unused; all other behaviour identical.
// TESTING (bench: N_BTN=5, DEBOUNCE_CNT=4, LONG_CNT=20)
//  1. Clean press, btn_in[0]=1 from edge E0 -> btn_press[0] high only in cycle after E0+7;
//     btn_level[0]=1 from then; evt_count=1.
//  2. Bounce, btn_in[1] toggles 1,0,1,0 every 3 cycles then steady 1 -> single btn_press[1]
//     7 edges after last rising; no btn_release[1].
//  3. Release glitch, held button drops to 0 for 3 cycles then 1 -> no btn_release; btn_level stays 1.
//  4. Simultaneous, btn_in[4:2]=3'b111 on one edge -> three press pulses same cycle;
//     evt_count +3. Also run 256 presses -> evt_count wraps to 0.
//  5. Long press (macro on), hold 40 cycles -> btn_long[0] single pulse at 21st cycle of HELD.
//     Macro off -> btn_long stays 0.
//  6. Reset mid-debounce, rst pulsed while DB_PRESS with btn held -> outputs 0 immediately.
//     After release of rst, btn_press after 7 edges.

Source files
------------

// File: rtl/zedboard_btn_debounce.sv
// zedboard_btn_debounce: per-channel push-button debouncer for the Zedboard fabric clock.
// Each channel has a 2-flop synchroniser followed by a four-state debounce FSM. The channel
// produces a clean level, one-cycle press and release pulses, and an optional long-press pulse.
// A shared wrapping counter tallies debounced presses across all channels.
// Optional feature macro: ZB_BTN_LONG_PRESS_EN enables the per-channel hold counter and btn_long.
// When the macro is undefined, btn_long is tied to 0 and LONG_CNT is only range-checked.
module zedboard_btn_debounce #(
    parameter int unsigned      N_BTN        = 5,
    parameter int unsigned      CNT_W        = 27,
    parameter logic [CNT_W-1:0] DEBOUNCE_CNT = CNT_W'(1249999),
    parameter logic [CNT_W-1:0] LONG_CNT     = CNT_W'(124999999)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [7:0]       evt_count
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    // The long-press compare uses LONG_CNT-1, so a zero terminal count is meaningless.
    if (LONG_CNT == '0) begin : g_bad_long_cnt
        $error("zedboard_btn_debounce: LONG_CNT must be non-zero");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] w_press_nxt;
    logic [7:0]       w_press_sum;
    logic [7:0]       r_evt_count;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_dcnt;
        logic [CNT_W-1:0] w_dcnt_nxt;
        logic             r_level;
        logic             w_level_nxt;
        logic             r_press;
        logic             w_press;
        logic             r_release;
        logic             w_release;
`ifdef ZB_BTN_LONG_PRESS_EN
        logic [CNT_W-1:0] r_hcnt;
        logic [CNT_W-1:0] w_hcnt_nxt;
        logic             r_long;
        logic             w_long;
`endif

        // FSM state, counters and registered outputs for this channel.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state   <= ST_IDLE;
                r_dcnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef ZB_BTN_LONG_PRESS_EN
                r_hcnt    <= '0;
                r_long    <= 1'b0;
`endif
            end else begin
                r_state   <= w_state_nxt;
                r_dcnt    <= w_dcnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press;
                r_release <= w_release;
`ifdef ZB_BTN_LONG_PRESS_EN
                r_hcnt    <= w_hcnt_nxt;
                r_long    <= w_long;
`endif
            end
        end

        // Next-state and next-output decode; pulses default low, level holds.
        always_comb begin
            w_state_nxt = r_state;
            w_dcnt_nxt  = r_dcnt;
            w_level_nxt = r_level;
            w_press     = 1'b0;
            w_release   = 1'b0;
`ifdef ZB_BTN_LONG_PRESS_EN
            w_hcnt_nxt  = r_hcnt;
            w_long      = 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2[i]) begin
                        w_state_nxt = ST_DB_PRESS;
                        w_dcnt_nxt  = '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_dcnt == DEBOUNCE_CNT) begin
                        w_state_nxt = ST_HELD;
                        w_level_nxt = 1'b1;
                        w_press     = 1'b1;
`ifdef ZB_BTN_LONG_PRESS_EN
                        w_hcnt_nxt  = '0;
`endif
                    end else begin
                        w_dcnt_nxt = r_dcnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt = ST_DB_RELEASE;
                        w_dcnt_nxt  = '0;
                    end else begin
`ifdef ZB_BTN_LONG_PRESS_EN
                        // Saturating hold count; the single step into LONG_CNT fires btn_long.
                        if (r_hcnt != LONG_CNT) begin
                            w_hcnt_nxt = r_hcnt + CNT_W'(1);
                        end
                        if (r_hcnt == (LONG_CNT - CNT_W'(1))) begin
                            w_long = 1'b1;
                        end
`endif
                    end
                end
                ST_DB_RELEASE: begin
                    if (r_sync2[i]) begin
                        w_state_nxt = ST_HELD;
                    end else if (r_dcnt == DEBOUNCE_CNT) begin
                        w_state_nxt = ST_IDLE;
                        w_level_nxt = 1'b0;
                        w_release   = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
        assign w_press_nxt[i] = w_press;
`ifdef ZB_BTN_LONG_PRESS_EN
        assign btn_long[i]    = r_long;
`else
        assign btn_long[i]    = 1'b0;
`endif
    end

    // Number of channels that will pulse btn_press on the coming edge.
    always_comb begin
        w_press_sum = '0;
        for (int unsigned j = 0; j < N_BTN; j++) begin
            w_press_sum = w_press_sum + 8'(w_press_nxt[j]);
        end
    end

    // Press-event counter, updated on the same edge as the press pulses; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_count <= '0;
        end else begin
            r_evt_count <= r_evt_count + w_press_sum;
        end
    end

    assign evt_count = r_evt_count;

endmodule

// File: tb/tb_zedboard_btn_debounce.sv
// tb_zedboard_btn_debounce: directed bench for zedboard_btn_debounce with
// DEBOUNCE_CNT=4 and LONG_CNT=20. Inputs change 1 ns after a rising edge, and outputs
// are sampled at that same point. If btn_in is set after edge k, the first edge that
// samples it is E0=k+1, and the press pulse is visible after edge E0+7 (8 ticks later).
module tb_zedboard_btn_debounce;

    localparam int unsigned N_BTN = 5;
    localparam int unsigned CNT_W = 27;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic [7:0]       evt_count;

    int n_tests = 0;
    int n_fail  = 0;

    zedboard_btn_debounce #(
        .N_BTN        (N_BTN),
        .CNT_W        (CNT_W),
        .DEBOUNCE_CNT (27'd4),
        .LONG_CNT     (27'd20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .evt_count   (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Press then release the channels in mask, leaving every channel idle afterwards.
    task automatic press_release(input logic [N_BTN-1:0] mask);
        btn_in = btn_in | mask;
        tick(8);
        btn_in = btn_in & ~mask;
        tick(8);
    endtask

    initial begin
        logic exp_long;
        rst    = 1'b1;
        btn_in = '0;
        tick(2);
        // Reset state
        check("rst_level",   32'(btn_level),   32'h0);
        check("rst_press",   32'(btn_press),   32'h0);
        check("rst_release", 32'(btn_release), 32'h0);
        check("rst_long",    32'(btn_long),    32'h0);
        check("rst_evt",     32'(evt_count),   32'h0);
        rst = 1'b0;
        tick(2);

        // 1. Clean press on channel 0
        btn_in[0] = 1'b1;
        tick(7);
        check("t1_press_early", 32'(btn_press[0]), 32'h0);
        check("t1_level_early", 32'(btn_level[0]), 32'h0);
        tick(1);
        check("t1_press",  32'(btn_press),   32'h01);
        check("t1_level",  32'(btn_level),   32'h01);
        tick(1);
        check("t1_press_one_cycle", 32'(btn_press), 32'h00);
        check("t1_level_hold",      32'(btn_level), 32'h01);
        check("t1_evt",             32'(evt_count), 32'd1);

        // 2. Bounce on channel 1: 3 cycles high, 3 low, 3 high, 3 low, then steady high
        for (int b = 0; b < 4; b++) begin
            btn_in[1] = (b % 2 == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                check("t2_no_press_bounce", 32'(btn_press[1]), 32'h0);
                check("t2_no_level_bounce", 32'(btn_level[1]), 32'h0);
            end
        end
        btn_in[1] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick(1);
            check("t2_no_press_early", 32'(btn_press[1]), 32'h0);
        end
        tick(1);
        check("t2_press", 32'(btn_press), 32'h02);
        check("t2_level", 32'(btn_level), 32'h03);
        tick(1);
        check("t2_evt",   32'(evt_count), 32'd2);

        // 3. Release glitch on channel 0: 3 cycles low, then high again
        btn_in[0] = 1'b0;
        tick(3);
        btn_in[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("t3_no_release", 32'(btn_release), 32'h0);
            check("t3_level_kept", 32'(btn_level),   32'h03);
            tick(1);
        end
        // Real release of channels 0 and 1
        btn_in[1:0] = 2'b00;
        tick(7);
        check("t3_release_early", 32'(btn_release), 32'h0);
        tick(1);
        check("t3_release",       32'(btn_release), 32'h03);
        check("t3_level_low",     32'(btn_level),   32'h00);
        check("t3_no_press",      32'(btn_press),   32'h00);
        tick(1);
        check("t3_release_one",   32'(btn_release), 32'h00);
        check("t3_evt_unchanged", 32'(evt_count),   32'd2);

        // 4. Simultaneous press on channels 4..2
        btn_in[4:2] = 3'b111;
        tick(8);
        check("t4_press3", 32'(btn_press), 32'h1C);
        check("t4_level3", 32'(btn_level), 32'h1C);
        tick(1);
        check("t4_evt",    32'(evt_count), 32'd5);
        btn_in[4:2] = 3'b000;
        tick(8);
        check("t4_release3", 32'(btn_release), 32'h1C);
        tick(2);
        // 250 single presses bring the count to 255; one more wraps it to 0
        for (int p = 0; p < 250; p++) press_release(5'b00100);
        check("t4_evt_255", 32'(evt_count), 32'd255);
        press_release(5'b00100);
        check("t4_evt_wrap0", 32'(evt_count), 32'd0);
        press_release(5'b11111);
        check("t4_evt_plus5", 32'(evt_count), 32'd5);

        // 5. Long press on channel 0, held 40 cycles
`ifdef ZB_BTN_LONG_PRESS_EN
        exp_long = 1'b1;
`else
        exp_long = 1'b0;
`endif
        btn_in[0] = 1'b1;
        tick(8);
        check("t5_press", 32'(btn_press), 32'h01);
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            if (k == 20) check("t5_long_pulse", 32'(btn_long), 32'(exp_long));
            else         check("t5_long_quiet", 32'(btn_long), 32'h0);
        end
        btn_in[0] = 1'b0;
        tick(8);
        check("t5_release", 32'(btn_release), 32'h01);
        check("t5_long_after", 32'(btn_long), 32'h0);
        tick(1);
        check("t5_evt", 32'(evt_count), 32'd6);

        // 6. Reset mid-debounce: channel 4 held, channel 3 in DB_PRESS
        btn_in[4] = 1'b1;
        tick(8);
        check("t6_level4", 32'(btn_level), 32'h10);
        btn_in[3] = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        check("t6_rst_level", 32'(btn_level), 32'h0);
        check("t6_rst_evt",   32'(evt_count), 32'h0);
        check("t6_rst_press", 32'(btn_press), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(7);
        check("t6_press_early", 32'(btn_press), 32'h0);
        check("t6_level_early", 32'(btn_level), 32'h0);
        tick(1);
        check("t6_press", 32'(btn_press), 32'h18);
        check("t6_level", 32'(btn_level), 32'h18);
        tick(1);
        check("t6_evt",   32'(evt_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
